int_to_ieee: RTL and testbench

// - Converts a 64-bit integer into an IEEE-754 binary64 (double) value.
// - Inverse of ieee_to_int; uses the same producer/consumer handshake.
// - Feeds pixel coordinates (drawx/drawy) and integer zoom steps into the

---
 rtl/fractal_fp_pkg.sv | 18 +
 rtl/int_to_ieee.sv | 126 ++++++++++++
 tb/tb_int_to_ieee.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/fractal_fp_pkg.sv
// Shared binary64 constants and the converter state type used by the
// integer/floating-point converters of the fractal datapath.
package fractal_fp_pkg;

  localparam int DP_BIAS  = 1023;
  localparam int DP_EXP_W = 11;
  localparam int DP_MAN_W = 52;

  typedef enum logic [2:0] {
    GET_A,
    UNPACK,
    NORMALISE,
    ROUND,
    PACK,
    PUT_Z
  } i2f_state_t;

endpackage

// File: rtl/int_to_ieee.sv
// Iterative 64-bit integer to IEEE-754 binary64 converter. One operand is
// accepted at a time; the magnitude is normalised one bit per cycle and then
// rounded to nearest-even before packing.
module int_to_ieee
  import fractal_fp_pkg::*;
#(
  parameter int SIGNED_IN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] a_in,
  input  logic        a_in_done,
  output logic        a_in_ack,
  output logic [63:0] z_out,
  output logic        z_out_done,
  input  logic        z_out_ack
);

  i2f_state_t            state;
  logic [63:0]           a_reg;
  logic [63:0]           mag;
  logic [DP_EXP_W-1:0]   exp_r;
  logic [DP_MAN_W-1:0]   man;
  logic                  sign;

  logic                  unpack_sign;
  logic [63:0]           unpack_mag;
  logic                  guard_bit;
  logic                  round_bit;
  logic                  sticky_bit;
  logic                  round_inc;
  logic [DP_MAN_W:0]     round_sum;

  // Sign/magnitude split of the captured operand; -2^63 wraps to 2^63 as unsigned
  always_comb begin
    unpack_sign = (SIGNED_IN != 0) && a_reg[63];
    unpack_mag  = unpack_sign ? (~a_reg + 64'd1) : a_reg;
  end

  // Round-to-nearest-even increment on the normalised magnitude
  always_comb begin
    guard_bit  = mag[10];
    round_bit  = mag[9];
    sticky_bit = |mag[8:0];
    round_inc  = guard_bit & (round_bit | sticky_bit | mag[11]);
    round_sum  = {1'b0, mag[62:11]} + {{DP_MAN_W{1'b0}}, round_inc};
  end

  // Conversion FSM with registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= GET_A;
      a_in_ack   <= 1'b0;
      z_out_done <= 1'b0;
      z_out      <= 64'h0;
      a_reg      <= 64'h0;
      mag        <= 64'h0;
      exp_r      <= '0;
      man        <= '0;
      sign       <= 1'b0;
    end else begin
      case (state)
        GET_A: begin
          if (a_in_ack && a_in_done) begin
            a_reg    <= a_in;
            a_in_ack <= 1'b0;
            state    <= UNPACK;
          end else begin
            a_in_ack <= 1'b1;
          end
        end

        UNPACK: begin
          sign  <= unpack_sign;
          mag   <= unpack_mag;
          exp_r <= DP_EXP_W'(DP_BIAS + 63);
          if (unpack_mag == 64'h0) begin
            z_out <= 64'h0;
            state <= PUT_Z;
          end else begin
            state <= NORMALISE;
          end
        end

        NORMALISE: begin
          if (mag[63]) begin
            state <= ROUND;
          end else begin
            mag   <= {mag[62:0], 1'b0};
            exp_r <= exp_r - DP_EXP_W'(1);
          end
        end

        ROUND: begin
          if (round_sum[DP_MAN_W]) begin
            man   <= '0;
            exp_r <= exp_r + DP_EXP_W'(1);
          end else begin
            man   <= round_sum[DP_MAN_W-1:0];
          end
          state <= PACK;
        end

        PACK: begin
          z_out      <= {sign, exp_r, man};
          z_out_done <= 1'b1;
          state      <= PUT_Z;
        end

        PUT_Z: begin
          if (z_out_done && z_out_ack) begin
            z_out_done <= 1'b0;
            state      <= GET_A;
          end else begin
            z_out_done <= 1'b1;
          end
        end

        default: begin
          state <= GET_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_ieee.sv
// Self-checking bench for int_to_ieee: a signed and an unsigned instance
// share the stimulus lines, expected results travel through a scoreboard.
module tb_int_to_ieee;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] a_in;
  logic        a_drive;
  logic        ack_drive;
  logic        sel_uns;

  logic        ack_s, done_s, ack_u, done_u;
  logic [63:0] z_s, z_u;
  logic        cur_ack, cur_done;
  logic [63:0] cur_z;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cap_cycle = 0;

  logic [63:0] exp_q[$];
  int          lat_q[$];
  string       tag_q[$];

  int_to_ieee #(.SIGNED_IN(1)) dut_s (
    .clk(clk), .reset(reset), .a_in(a_in),
    .a_in_done(a_drive & ~sel_uns), .a_in_ack(ack_s),
    .z_out(z_s), .z_out_done(done_s), .z_out_ack(ack_drive & ~sel_uns)
  );

  int_to_ieee #(.SIGNED_IN(0)) dut_u (
    .clk(clk), .reset(reset), .a_in(a_in),
    .a_in_done(a_drive & sel_uns), .a_in_ack(ack_u),
    .z_out(z_u), .z_out_done(done_u), .z_out_ack(ack_drive & sel_uns)
  );

  assign cur_ack  = sel_uns ? ack_u  : ack_s;
  assign cur_done = sel_uns ? done_u : done_s;
  assign cur_z    = sel_uns ? z_u    : z_s;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [63:0] a, input logic [63:0] z,
                               input int lat, input bit uns);
    int n = 0;
    sel_uns = uns;
    @(negedge clk);
    while (!cur_ack && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_ack_wait"}, 64'(cur_ack), 64'd1);
    a_in    = a;
    a_drive = 1'b1;
    tag_q.push_back(tag);
    exp_q.push_back(z);
    lat_q.push_back(lat);
    @(negedge clk);
    cap_cycle = cyc;
    a_drive   = 1'b0;
  endtask

  task automatic collectResult(input int hold);
    int          n = 0;
    string       tag;
    logic [63:0] z;
    int          lat;
    int          seen;
    bit          stable;
    while (!cur_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    seen = cyc - cap_cycle;
    tag  = tag_q.pop_front();
    z    = exp_q.pop_front();
    lat  = lat_q.pop_front();
    checkOutput({tag, "_done"}, 64'(cur_done), 64'd1);
    checkOutput({tag, "_z"}, cur_z, z);
    checkOutput({tag, "_latency"}, 64'(seen), 64'(lat));
    if (hold > 0) begin
      stable = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if (!cur_done || cur_z !== z) stable = 1'b0;
      end
      checkOutput({tag, "_hold"}, 64'(stable), 64'd1);
    end
    ack_drive = 1'b1;
    @(negedge clk);
    ack_drive = 1'b0;
    checkOutput({tag, "_done_clear"}, 64'(cur_done), 64'd0);
    checkOutput({tag, "_ack_gap"}, 64'(cur_ack), 64'd0);
    @(negedge clk);
    checkOutput({tag, "_ack_rise"}, 64'(cur_ack), 64'd1);
    checkOutput({tag, "_z_kept"}, cur_z, z);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ok;
    reset     = 1'b1;
    a_in      = 64'h0;
    a_drive   = 1'b0;
    ack_drive = 1'b0;
    sel_uns   = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_ack_s", 64'(ack_s), 64'd0);
    checkOutput("rst_done_s", 64'(done_s), 64'd0);
    checkOutput("rst_z_s", z_s, 64'h0);
    checkOutput("rst_ack_u", 64'(ack_u), 64'd0);
    checkOutput("rst_z_u", z_u, 64'h0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_ack", 64'(ack_s), 64'd1);

    applyStimulus("one", 64'd1, 64'h3FF0000000000000, 67, 1'b0);
    collectResult(20);
    applyStimulus("two", 64'd2, 64'h4000000000000000, 66, 1'b0);
    collectResult(0);
    applyStimulus("neg3", 64'hFFFF_FFFF_FFFF_FFFD, 64'hC008000000000000, 66, 1'b0);
    collectResult(0);
    applyStimulus("zero", 64'd0, 64'h0000000000000000, 2, 1'b0);
    collectResult(0);
    applyStimulus("tie_even", 64'h0020_0000_0000_0001, 64'h4340000000000000, 14, 1'b0);
    collectResult(0);
    applyStimulus("round_up", 64'h0020_0000_0000_0003, 64'h4340000000000002, 14, 1'b0);
    collectResult(0);
    applyStimulus("carry_exp", 64'h7FFF_FFFF_FFFF_FFFF, 64'h43E0000000000000, 5, 1'b0);
    collectResult(0);
    applyStimulus("min_neg", 64'h8000_0000_0000_0000, 64'hC3E0000000000000, 4, 1'b0);
    collectResult(0);

    applyStimulus("u_ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'h43F0000000000000, 4, 1'b1);
    collectResult(0);
    applyStimulus("u_top", 64'h8000_0000_0000_0000, 64'h43E0000000000000, 4, 1'b1);
    collectResult(0);
    applyStimulus("u_one", 64'd1, 64'h3FF0000000000000, 67, 1'b1);
    collectResult(0);

    applyStimulus("busy", 64'd1, 64'h3FF0000000000000, 67, 1'b0);
    repeat (5) @(negedge clk);
    a_in    = 64'd5;
    a_drive = 1'b1;
    ok      = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (cur_ack) ok = 1'b0;
    end
    a_drive = 1'b0;
    checkOutput("busy_no_ack", 64'(ok), 64'd1);
    collectResult(0);

    applyStimulus("abort", 64'd1, 64'h3FF0000000000000, 67, 1'b0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_ack", 64'(ack_s), 64'd0);
    checkOutput("abort_done", 64'(done_s), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_ack_rise", 64'(ack_s), 64'd1);
    void'(tag_q.pop_front());
    void'(exp_q.pop_front());
    void'(lat_q.pop_front());
    repeat (80) @(negedge clk);
    checkOutput("abort_no_result", 64'(done_s), 64'd0);

    applyStimulus("after_abort", 64'd2, 64'h4000000000000000, 66, 1'b0);
    collectResult(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
